// File: rtl/timer_cfg_sched_if.sv
// timer_cfg_sched_if: config/debug inputs and counter-control outputs of the timer config sequencer
interface timer_cfg_sched_if;
  logic       cfg_wr;
  logic       cfg_timer_en;
  logic       cfg_div_en;
  logic [3:0] cfg_div_val;
  logic       dbg_mode;
  logic       dbg_halt_req;
  logic       cnt_en;
  logic       timer_en;
  logic       div_en;
  logic [3:0] div_val;
  logic       halt_req;
  logic       dbg_halt_ack;
  logic       cfg_busy;
  logic       cfg_err;
  modport master (
    output cfg_wr, cfg_timer_en, cfg_div_en, cfg_div_val, dbg_mode, dbg_halt_req, cnt_en,
    input  timer_en, div_en, div_val, halt_req, dbg_halt_ack, cfg_busy, cfg_err
  );
  modport slave (
    input  cfg_wr, cfg_timer_en, cfg_div_en, cfg_div_val, dbg_mode, dbg_halt_req, cnt_en,
    output timer_en, div_en, div_val, halt_req, dbg_halt_ack, cfg_busy, cfg_err
  );
endinterface

// File: rtl/timer_cfg_sched.sv
// timer_cfg_sched: sequences config writes and debug halt onto the counter-control inputs
module timer_cfg_sched #(
  parameter int DIV_MAX = 8
) (
  input logic               clk,
  input logic               rst,
  timer_cfg_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t     state_q, state_d;
  logic       timer_en_q, timer_en_d, div_en_q, div_en_d, halt_req_q, halt_req_d;
  logic       ack_q, ack_d, pend_q, pend_d, pend_en_q, pend_en_d, err_q, err_d;
  logic [3:0] div_val_q, div_val_d, pend_val_q, pend_val_d;
  logic       halt_eff, wr_bad, wr_ok, apply;
  assign halt_eff = bus.dbg_mode & bus.dbg_halt_req;
  assign wr_bad   = bus.cfg_wr & bus.cfg_div_en & (bus.cfg_div_val > 4'(DIV_MAX));
  assign wr_ok    = bus.cfg_wr & ~wr_bad;
  // Pending only lands on an unfrozen prescaler boundary
  assign apply    = pend_q & bus.cnt_en & ~halt_req_q;
  always_comb begin
    state_d    = state_q;
    timer_en_d = timer_en_q;
    halt_req_d = halt_req_q;
    ack_d      = ack_q;
    err_d      = wr_bad;
    pend_en_d  = pend_en_q;
    pend_val_d = pend_val_q;
    div_en_d   = apply ? pend_en_q : div_en_q;
    div_val_d  = apply ? pend_val_q : div_val_q;
    pend_d     = pend_q & ~apply;
    case (state_q)
      IDLE: if (wr_ok) begin
        div_en_d  = bus.cfg_div_en;
        div_val_d = bus.cfg_div_val;
        if (bus.cfg_timer_en) begin
          timer_en_d = 1'b1;
          state_d    = halt_eff ? HALT : RUN;
          halt_req_d = halt_eff;
        end
      end
      default: begin
        state_d    = halt_eff ? HALT : RUN;
        halt_req_d = halt_eff;
        ack_d      = (state_q == HALT) & halt_eff & halt_req_q;
        // Compare against post-apply outputs so a simultaneous write pends only if still different
        if (wr_ok && !bus.cfg_timer_en) begin
          state_d    = IDLE;
          timer_en_d = 1'b0;
          div_en_d   = bus.cfg_div_en;
          div_val_d  = bus.cfg_div_val;
          pend_d     = 1'b0;
          halt_req_d = 1'b0;
          ack_d      = 1'b0;
        end else if (wr_ok && {bus.cfg_div_en, bus.cfg_div_val} != {div_en_d, div_val_d}) begin
          pend_d     = 1'b1;
          pend_en_d  = bus.cfg_div_en;
          pend_val_d = bus.cfg_div_val;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_en_q <= 1'b0;
      div_en_q   <= 1'b0;
      div_val_q  <= 4'd0;
      halt_req_q <= 1'b0;
      ack_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_en_q  <= 1'b0;
      pend_val_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_en_q <= timer_en_d;
      div_en_q   <= div_en_d;
      div_val_q  <= div_val_d;
      halt_req_q <= halt_req_d;
      ack_q      <= ack_d;
      pend_q     <= pend_d;
      pend_en_q  <= pend_en_d;
      pend_val_q <= pend_val_d;
      err_q      <= err_d;
    end
  end
  assign bus.timer_en     = timer_en_q;
  assign bus.div_en       = div_en_q;
  assign bus.div_val      = div_val_q;
  assign bus.halt_req     = halt_req_q;
  assign bus.dbg_halt_ack = ack_q;
  assign bus.cfg_busy     = pend_q;
  assign bus.cfg_err      = err_q;
endmodule

// File: tb/tb_timer_cfg_sched.sv
// tb_timer_cfg_sched: directed scenarios for timer_cfg_sched with hand-computed outputs
module tb_timer_cfg_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   miss = 0;
  timer_cfg_sched_if bus ();
  timer_cfg_sched #(.DIV_MAX(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // {timer_en, div_en, div_val[3:0], halt_req, dbg_halt_ack, cfg_busy, cfg_err}
  logic [9:0] outs;
  assign outs = {bus.timer_en, bus.div_en, bus.div_val, bus.halt_req, bus.dbg_halt_ack, bus.cfg_busy, bus.cfg_err};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic te, input logic de, input logic [3:0] dv);
    bus.cfg_wr = 1'b1; bus.cfg_timer_en = te; bus.cfg_div_en = de; bus.cfg_div_val = dv;
  endtask
  task automatic test_reset();
    bus.cfg_wr = 0; bus.cfg_timer_en = 0; bus.cfg_div_en = 0; bus.cfg_div_val = 0;
    bus.dbg_mode = 0; bus.dbg_halt_req = 0; bus.cnt_en = 0;
    rst = 1'b1;
    tick();
    vec++; if (outs !== 10'b0) begin miss++; $display("FAIL reset got=%b exp=%b", outs, 10'b0); end
    rst = 1'b0;
    tick();
    vec++; if (outs !== 10'b0) begin miss++; $display("FAIL reset_idle got=%b exp=%b", outs, 10'b0); end
  endtask
  task automatic test_idle_write();
    wr(1, 1, 4'd3); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0011_0000) begin miss++; $display("FAIL idle_write got=%b exp=%b", outs, 10'b1_1_0011_0000); end
    tick();
    vec++; if (outs !== 10'b1_1_0011_0000) begin miss++; $display("FAIL run_hold got=%b exp=%b", outs, 10'b1_1_0011_0000); end
  endtask
  task automatic test_pending();
    wr(1, 1, 4'd1); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0011_0010) begin miss++; $display("FAIL pend_set got=%b exp=%b", outs, 10'b1_1_0011_0010); end
    tick();
    vec++; if (outs !== 10'b1_1_0011_0010) begin miss++; $display("FAIL pend_hold got=%b exp=%b", outs, 10'b1_1_0011_0010); end
    bus.cnt_en = 1; tick(); bus.cnt_en = 0;
    vec++; if (outs !== 10'b1_1_0001_0000) begin miss++; $display("FAIL pend_apply got=%b exp=%b", outs, 10'b1_1_0001_0000); end
  endtask
  task automatic test_err();
    wr(1, 1, 4'd9); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0001_0001) begin miss++; $display("FAIL err_pulse got=%b exp=%b", outs, 10'b1_1_0001_0001); end
    tick();
    vec++; if (outs !== 10'b1_1_0001_0000) begin miss++; $display("FAIL err_drop got=%b exp=%b", outs, 10'b1_1_0001_0000); end
  endtask
  task automatic test_halt();
    bus.dbg_mode = 1; bus.dbg_halt_req = 1; tick();
    vec++; if (outs !== 10'b1_1_0001_1000) begin miss++; $display("FAIL halt_req got=%b exp=%b", outs, 10'b1_1_0001_1000); end
    tick();
    vec++; if (outs !== 10'b1_1_0001_1100) begin miss++; $display("FAIL halt_ack got=%b exp=%b", outs, 10'b1_1_0001_1100); end
    wr(1, 1, 4'd2); bus.cnt_en = 1; tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0001_1110) begin miss++; $display("FAIL halt_pend got=%b exp=%b", outs, 10'b1_1_0001_1110); end
    tick();
    vec++; if (outs !== 10'b1_1_0001_1110) begin miss++; $display("FAIL halt_noapply got=%b exp=%b", outs, 10'b1_1_0001_1110); end
    bus.cnt_en = 0; bus.dbg_halt_req = 0; tick();
    vec++; if (outs !== 10'b1_1_0001_0010) begin miss++; $display("FAIL halt_release got=%b exp=%b", outs, 10'b1_1_0001_0010); end
    bus.cnt_en = 1; tick(); bus.cnt_en = 0;
    vec++; if (outs !== 10'b1_1_0010_0000) begin miss++; $display("FAIL resume_apply got=%b exp=%b", outs, 10'b1_1_0010_0000); end
  endtask
  task automatic test_dbg_mode();
    bus.dbg_mode = 0; bus.dbg_halt_req = 1; tick(); tick();
    vec++; if (outs !== 10'b1_1_0010_0000) begin miss++; $display("FAIL no_dbg_halt got=%b exp=%b", outs, 10'b1_1_0010_0000); end
    bus.dbg_mode = 1; tick();
    vec++; if (outs !== 10'b1_1_0010_1000) begin miss++; $display("FAIL dbg_halt got=%b exp=%b", outs, 10'b1_1_0010_1000); end
    bus.dbg_mode = 0; tick();
    vec++; if (outs !== 10'b1_1_0010_0000) begin miss++; $display("FAIL dbg_fall got=%b exp=%b", outs, 10'b1_1_0010_0000); end
    bus.dbg_halt_req = 0;
  endtask
  task automatic test_back_to_back();
    wr(1, 1, 4'd4); tick();
    vec++; if (outs !== 10'b1_1_0010_0010) begin miss++; $display("FAIL b2b_pend got=%b exp=%b", outs, 10'b1_1_0010_0010); end
    wr(1, 1, 4'd2); bus.cnt_en = 1; tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0100_0010) begin miss++; $display("FAIL b2b_apply got=%b exp=%b", outs, 10'b1_1_0100_0010); end
    tick(); bus.cnt_en = 0;
    vec++; if (outs !== 10'b1_1_0010_0000) begin miss++; $display("FAIL b2b_apply2 got=%b exp=%b", outs, 10'b1_1_0010_0000); end
    wr(1, 1, 4'd2); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0010_0000) begin miss++; $display("FAIL same_write got=%b exp=%b", outs, 10'b1_1_0010_0000); end
  endtask
  task automatic test_halt_disable();
    wr(1, 1, 4'd5); bus.dbg_mode = 1; bus.dbg_halt_req = 1; tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0010_1010) begin miss++; $display("FAIL wr_and_halt got=%b exp=%b", outs, 10'b1_1_0010_1010); end
    tick();
    vec++; if (outs !== 10'b1_1_0010_1110) begin miss++; $display("FAIL wr_halt_ack got=%b exp=%b", outs, 10'b1_1_0010_1110); end
    wr(0, 0, 4'd0); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b0) begin miss++; $display("FAIL halt_disable got=%b exp=%b", outs, 10'b0); end
    tick();
    vec++; if (outs !== 10'b0) begin miss++; $display("FAIL idle_ignores_halt got=%b exp=%b", outs, 10'b0); end
  endtask
  task automatic test_idle_halt();
    wr(1, 0, 4'd0); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_0_0000_1000) begin miss++; $display("FAIL idle_to_halt got=%b exp=%b", outs, 10'b1_0_0000_1000); end
    tick();
    vec++; if (outs !== 10'b1_0_0000_1100) begin miss++; $display("FAIL idle_halt_ack got=%b exp=%b", outs, 10'b1_0_0000_1100); end
    bus.dbg_halt_req = 0; tick();
    vec++; if (outs !== 10'b1_0_0000_0000) begin miss++; $display("FAIL idle_halt_rel got=%b exp=%b", outs, 10'b1_0_0000_0000); end
    wr(0, 0, 4'd0); tick(); bus.cfg_wr = 0;
  endtask
  task automatic test_boundary();
    wr(0, 1, 4'd8); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b0_1_1000_0000) begin miss++; $display("FAIL div_max got=%b exp=%b", outs, 10'b0_1_1000_0000); end
    wr(0, 0, 4'd9); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b0_0_1001_0000) begin miss++; $display("FAIL div_off_big got=%b exp=%b", outs, 10'b0_0_1001_0000); end
    wr(0, 1, 4'd15); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b0_0_1001_0001) begin miss++; $display("FAIL idle_err got=%b exp=%b", outs, 10'b0_0_1001_0001); end
  endtask
  task automatic test_async_reset();
    wr(1, 1, 4'd3); tick();
    wr(1, 1, 4'd6); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0011_0010) begin miss++; $display("FAIL pre_rst got=%b exp=%b", outs, 10'b1_1_0011_0010); end
    #2 rst = 1'b1;
    #1;
    vec++; if (outs !== 10'b0) begin miss++; $display("FAIL async_rst got=%b exp=%b", outs, 10'b0); end
    tick(); rst = 1'b0; bus.cnt_en = 1; tick(); bus.cnt_en = 0;
    vec++; if (outs !== 10'b0) begin miss++; $display("FAIL pend_lost got=%b exp=%b", outs, 10'b0); end
    wr(1, 1, 4'd3); tick(); bus.cfg_wr = 0;
    vec++; if (outs !== 10'b1_1_0011_0000) begin miss++; $display("FAIL post_rst_wr got=%b exp=%b", outs, 10'b1_1_0011_0000); end
  endtask
  initial begin
    test_reset();
    test_idle_write();
    test_pending();
    test_err();
    test_halt();
    test_dbg_mode();
    test_back_to_back();
    test_halt_disable();
    test_idle_halt();
    test_boundary();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
